// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
// No logic; combinational helper only.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between an add requester (master) and serial_adder (slave).
// start is only honoured while busy is low.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR of their carries.
// Purely combinational; no backpressure.
module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x_i(a_i), .y_i(b_i), .s_o(s0),  .c_o(c0));
    half_adder u_ha1 (.x_i(s0),  .y_i(c_i), .s_o(s_o), .c_o(c1));

    assign c_o = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, {cout,sum} = a + b + cin, one bit per clock LSB-first.
// Latency WIDTH+1 edges from accept to done; start is ignored while busy.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sreg_q,    sreg_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    logic             cout_q,    cout_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic fa_sum;
    logic fa_carry;

    full_adder_bit u_fa (
        .a_i (shift_a_q[0]),
        .b_i (shift_b_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sreg_d    = sreg_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;

        case (state_q)
            ST_RUN: begin
                sreg_d    = {fa_sum, sreg_q[WIDTH-1:1]};
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = fa_carry;
                if (cnt_q == LAST) begin
                    // Results become visible only on the final step edge.
                    state_d = ST_DONE;
                    sum_d   = sreg_d;
                    cout_d  = fa_carry;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE, DONE and the unused encoding all accept a new add.
                if (bus.start) begin
                    state_d   = ST_RUN;
                    shift_a_d = bus.a;
                    shift_b_d = bus.b;
                    carry_d   = bus.cin;
                    cnt_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sreg_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sreg_q    <= sreg_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
